// File: rtl/uart_tx_framer.sv
// ---------------------------------------------------------------------------
// uart_tx_framer
//
// Buffers 16-bit decoder result words in a small FIFO and, once a full
// frame's worth of words is queued, streams a byte frame to a UART
// transmitter:  HEADER, sequence number, MSB/LSB of each word,
// optional checksum.  Each byte is offered with a one-cycle strobe and the
// next byte is held back until the transmitter's ready flag has been seen
// low, because the transmitter keeps ready high for a few cycles after it
// has taken a byte.
//
// Build option:
//   UART_TX_FRAMER_CHECKSUM_EN  when defined, a checksum byte (XOR of the
//                               sequence number and all data bytes) follows
//                               the last data byte.
//
// Parameters:
//   WORDS_PER_FRAME  16-bit words per frame (1..15)
//   FIFO_DEPTH       word FIFO depth (power of 2, >= WORDS_PER_FRAME)
//   HEADER           frame start byte
//
// Ports:
//   i_clk_sys     system clock
//   i_rst_n       asynchronous active-low reset
//   i_word        word to queue
//   i_word_valid  push strobe (dropped, and overflow flagged, when full)
//   o_word_ready  registered FIFO-not-full
//   i_tx_ready    UART transmitter idle flag
//   o_tx_data     byte to the UART, held until ready falls
//   o_tx_valid    single-cycle byte strobe
//   o_busy        frame in progress
//   o_overflow    sticky word-drop flag
//   o_seq         sequence number of the next frame
// ---------------------------------------------------------------------------
module uart_tx_framer #(
    parameter int unsigned WORDS_PER_FRAME = 4,
    parameter int unsigned FIFO_DEPTH      = 16,
    parameter logic [7:0]  HEADER          = 8'hA5
) (
    input  logic        i_clk_sys,
    input  logic        i_rst_n,
    input  logic [15:0] i_word,
    input  logic        i_word_valid,
    output logic        o_word_ready,
    input  logic        i_tx_ready,
    output logic [7:0]  o_tx_data,
    output logic        o_tx_valid,
    output logic        o_busy,
    output logic        o_overflow,
    output logic [7:0]  o_seq
);

    localparam int unsigned      PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned      CNT_W     = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);
    localparam logic [CNT_W-1:0] WPF_C     = CNT_W'(WORDS_PER_FRAME);
    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(FIFO_DEPTH - 1);
    localparam logic [3:0]       LAST_WORD = 4'(WORDS_PER_FRAME - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SEQ,
        ST_DATA_HI,
        ST_DATA_LO,
`ifdef UART_TX_FRAMER_CHECKSUM_EN
        ST_CSUM,
`endif
        ST_DONE
    } state_e;

    typedef enum logic {
        HS_ARMED,
        HS_WAIT_LOW
    } hs_e;

    state_e            state_q, state_d;
    hs_e               hs_q, hs_d;
    logic [15:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              word_ready_q, word_ready_d;
    logic              overflow_q, overflow_d;
    logic              tx_valid_q, tx_valid_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic [7:0]        seq_q, seq_d;
    logic [3:0]        word_cnt_q, word_cnt_d;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic              full;
    logic              push;
    logic              pop;
    logic              fire;
    logic              is_byte_state;
    logic [7:0]        cur_byte;
    logic [15:0]       head_word;

    assign head_word = mem_q[rd_ptr_q];

    // FIFO bookkeeping; a push while full is dropped and latches overflow.
    // Ready is computed from the next count so it is registered yet exact.
    always_comb begin
        full         = (count_q == DEPTH_C);
        push         = i_word_valid && !full;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        if (push) begin
            wr_ptr_d = (wr_ptr_q == LAST_PTR) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = (rd_ptr_q == LAST_PTR) ? '0 : rd_ptr_q + 1'b1;
        end
        count_d      = count_q + CNT_W'(push) - CNT_W'(pop);
        word_ready_d = (count_d != DEPTH_C);
        overflow_d   = overflow_q || (i_word_valid && full);
    end

    // Frame sequencer plus byte sub-handshake.  The frame state advances in
    // the cycle a byte is launched; the sub-handshake then blocks the next
    // launch until ready has been observed low.
    always_comb begin
        state_d       = state_q;
        hs_d          = hs_q;
        tx_valid_d    = 1'b0;
        tx_data_d     = tx_data_q;
        seq_d         = seq_q;
        word_cnt_d    = word_cnt_q;
        pop           = 1'b0;
        cur_byte      = HEADER;
        is_byte_state = 1'b1;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
        csum_d        = csum_q;
`endif

        case (state_q)
            ST_HDR:     cur_byte = HEADER;
            ST_SEQ:     cur_byte = seq_q;
            ST_DATA_HI: cur_byte = head_word[15:8];
            ST_DATA_LO: cur_byte = head_word[7:0];
`ifdef UART_TX_FRAMER_CHECKSUM_EN
            ST_CSUM:    cur_byte = csum_q;
`endif
            default:    is_byte_state = 1'b0;
        endcase

        fire = is_byte_state && (hs_q == HS_ARMED) && i_tx_ready;

        if (hs_q == HS_WAIT_LOW && !i_tx_ready) begin
            hs_d = HS_ARMED;
        end
        if (fire) begin
            tx_valid_d = 1'b1;
            tx_data_d  = cur_byte;
            hs_d       = HS_WAIT_LOW;
        end

`ifdef UART_TX_FRAMER_CHECKSUM_EN
        if (fire && state_q == ST_SEQ) begin
            csum_d = seq_q;
        end else if (fire && (state_q == ST_DATA_HI || state_q == ST_DATA_LO)) begin
            csum_d = csum_q ^ cur_byte;
        end
`endif

        case (state_q)
            ST_IDLE: begin
                if (count_q >= WPF_C) begin
                    state_d = ST_HDR;
                end
            end
            ST_HDR: begin
                if (fire) state_d = ST_SEQ;
            end
            ST_SEQ: begin
                if (fire) state_d = ST_DATA_HI;
            end
            ST_DATA_HI: begin
                if (fire) state_d = ST_DATA_LO;
            end
            ST_DATA_LO: begin
                if (fire) begin
                    pop = 1'b1;
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d = '0;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
                        state_d    = ST_CSUM;
`else
                        state_d    = ST_DONE;
`endif
                    end else begin
                        word_cnt_d = word_cnt_q + 4'd1;
                        state_d    = ST_DATA_HI;
                    end
                end
            end
`ifdef UART_TX_FRAMER_CHECKSUM_EN
            ST_CSUM: begin
                if (fire) state_d = ST_DONE;
            end
`endif
            ST_DONE: begin
                seq_d   = seq_q + 8'd1;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Word storage has no reset; only the pointers and count define contents.
    always_ff @(posedge i_clk_sys) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_word;
        end
    end

    // Control and output registers.
    always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= ST_IDLE;
            hs_q         <= HS_ARMED;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            word_ready_q <= 1'b1;
            overflow_q   <= 1'b0;
            tx_valid_q   <= 1'b0;
            tx_data_q    <= 8'h00;
            seq_q        <= 8'h00;
            word_cnt_q   <= '0;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
            csum_q       <= 8'h00;
`endif
        end else begin
            state_q      <= state_d;
            hs_q         <= hs_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            word_ready_q <= word_ready_d;
            overflow_q   <= overflow_d;
            tx_valid_q   <= tx_valid_d;
            tx_data_q    <= tx_data_d;
            seq_q        <= seq_d;
            word_cnt_q   <= word_cnt_d;
`ifdef UART_TX_FRAMER_CHECKSUM_EN
            csum_q       <= csum_d;
`endif
        end
    end

    assign o_word_ready = word_ready_q;
    assign o_overflow   = overflow_q;
    assign o_tx_valid   = tx_valid_q;
    assign o_tx_data    = tx_data_q;
    assign o_seq        = seq_q;
    assign o_busy       = (state_q != ST_IDLE);

endmodule
